rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Parametrised reset sequencer for a pu32 SoC top.
- Replaces the single hand-coded reset counter and the rst0/rst1 decode with one block. It covers N reset domains, M PLL-lock inputs, staggered per-domain release, cold/warm/power-off software requests, and a reset-cause register.
- Sits between the clock PLLs, devtbl rst0/rst1 and multipu rst_o on one side, and every peripheral and core rst_i on the other.
- Runs on the slowest system clock, clk_w[0].

Parameters:
- DOMAINCOUNT, 4: number of reset domains; must be >= 1.
- LOCKCOUNT, 2: number of PLL-locked inputs; must be >= 1.
- CNTRBITSZ, 16: width of the release counter; it is loaded with all-ones.
- STAGGER, 256: cycles between successive domain releases; 0 means all domains release together.
- GSRCYCLES, 4: length of the gsr_o pulse for a cold reset; must be >= 1.

Ports:
- clk_i, in, 1: system clock; one clock domain only.
- rst_i, in, 1: synchronous active-high reset (external button, already synchronised).
- locked_i, in, LOCKCOUNT: PLL locked flags, active-high.
- swrst_i, in, 2: {rst1,rst0} from devtbl. 11 = cold, 10 = warm, 01 = power-off, 00 = none.
- rqst_i, in, 1: reset-hold request, e.g. from multipu rst_o; level-sensitive.
- rst_o, out, DOMAINCOUNT: per-domain reset, active-high.
- gsr_o, out, 1: global set/reset pulse, drives STARTUPE2.GSR.
- pwroff_o, out, 1: latched power-off indication.
- ready_o, out, 1: all domains released.
- cause_o, out, 3: cause of the last reset.

Behaviour:
- All outputs are registered.
- Cause codes: POR=0, EXT=1, LOCKLOSS=2, COLD=3, WARM=4, RQST=5, PWROFF=6.
- Power-up initial values (register init): state HOLD, rst_o all-ones, gsr_o=0, pwroff_o=0, ready_o=0, cause_o=POR.
- rst_i=1 (highest priority, in every state): next cycle state=HOLD, rst_o all-ones, gsr_o=0, pwroff_o=0 (clears OFF), ready_o=0, cause_o=EXT.
- HOLD:
  - rst_o all-ones.
  - If &locked_i: go to COUNT, with cntr=all-ones.
  - swrst warm and rqst_i are ignored here; cold and power-off are honoured.
- COUNT:
  - rst_o all-ones.
  - If rqst_i or swrst=warm: reload cntr to all-ones each cycle and stay.
  - Otherwise decrement cntr.
  - When cntr==0 is registered at cycle T: go to RELEASE; rst_o[0] goes low at T+1.
- RELEASE:
  - rst_o[k] goes low at T+1+k*STAGGER.
  - Released domains stay low.
  - ready_o rises in the same cycle the last domain goes low; state becomes RUN.
  - STAGGER=0: all domains go low at T+1.
- RUN: rst_o all-zeros, ready_o=1.
- Events in COUNT, RELEASE and RUN are evaluated every cycle, in this priority order:
  1. Any locked_i low → HOLD, cause LOCKLOSS.
  2. swrst=power-off → OFF, cause PWROFF.
  3. swrst=cold → COLD, cause COLD.
  4. swrst=warm → COUNT with reload, cause WARM.
  5. rqst_i → COUNT with reload, cause RQST.
- For every event above:
  - rst_o goes all-ones and ready_o=0 on the next cycle.
  - cause_o updates in the same cycle.
  - A mid-RELEASE event re-asserts already-released domains.
- In HOLD, power-off and cold follow the same priority order; lock loss there is not an event.
- COLD:
  - gsr_o=1 for exactly GSRCYCLES cycles, with rst_o all-ones.
  - Then state=HOLD and gsr_o=0.
  - swrst_i and rqst_i are ignored during COLD.
- OFF:
  - pwroff_o=1, rst_o all-ones.
  - Every input except rst_i is ignored; only rst_i exits.
- Warm or rqst held continuously: stays in COUNT indefinitely; the counter restarts from all-ones after the request drops.
- Counter: no wrap; it decrements only while non-zero. The stagger counter is ceil(log2(STAGGER+1)) bits.
- cause_o holds its value until the next event; it is not cleared on RUN.

Decomposition:
- Shared package rst_seq_pkg:
  - state encoding: HOLD, COUNT, RELEASE, RUN, COLD, OFF;
  - cause codes (3-bit constants);
  - swrst encodings SWRST_NONE, SWRST_PWROFF, SWRST_WARM, SWRST_COLD.
- Single module with no sub-module. The release counter, stagger counter and domain index all live inside the FSM.

Test Plan:
Bench settings: CNTRBITSZ=4, STAGGER=2, DOMAINCOUNT=3, LOCKCOUNT=2, GSRCYCLES=4.
- Power-up, locked_i=11 sampled at t0 → rst_o[0] low at t0+17, rst_o[1] at t0+19, rst_o[2] and ready_o=1 at t0+21, cause_o=POR.
- In RUN, drop locked_i[1] for 1 cycle → rst_o=111 and cause=LOCKLOSS next cycle; after relock, the full 17/19/21 sequence repeats.
- In RUN, swrst=10 held for 5 cycles then 00 → rst_o=111 throughout; rst_o[0] low 16 cycles after the first cycle with swrst=00; cause=WARM.
- In RELEASE with rst_o=110, assert rst_i → rst_o=111, cause=EXT, HOLD.
- swrst=11 → gsr_o high exactly 4 cycles, then HOLD, cause=COLD.
- swrst=01 in RUN → pwroff_o=1 and rst_o=111 permanently.
  - Later cold and warm requests are ignored.
  - rst_i clears pwroff_o and sets cause=EXT.
- Simultaneous lock loss and swrst=11 in RUN → cause=LOCKLOSS, gsr_o stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes
// and the devtbl {rst1,rst0} software reset request values.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    COUNT,
    RELEASE,
    RUN,
    COLD,
    OFF
  } state_t;

  localparam logic [2:0] CAUSE_POR      = 3'd0;
  localparam logic [2:0] CAUSE_EXT      = 3'd1;
  localparam logic [2:0] CAUSE_LOCKLOSS = 3'd2;
  localparam logic [2:0] CAUSE_COLD     = 3'd3;
  localparam logic [2:0] CAUSE_WARM     = 3'd4;
  localparam logic [2:0] CAUSE_RQST     = 3'd5;
  localparam logic [2:0] CAUSE_PWROFF   = 3'd6;

  localparam logic [1:0] SWRST_NONE   = 2'b00;
  localparam logic [1:0] SWRST_PWROFF = 2'b01;
  localparam logic [1:0] SWRST_WARM   = 2'b10;
  localparam logic [1:0] SWRST_COLD   = 2'b11;

  // Bits needed to hold 0..n, never less than one.
  function automatic int ctr_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains in reset until every PLL is locked,
// counts down, then releases domains one after another and tracks the cause.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int DOMAINCOUNT = 4,
  parameter int LOCKCOUNT   = 2,
  parameter int CNTRBITSZ   = 16,
  parameter int STAGGER     = 256,
  parameter int GSRCYCLES   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LOCKCOUNT-1:0]   locked_i,
  input  logic [1:0]             swrst_i,
  input  logic                   rqst_i,
  output logic [DOMAINCOUNT-1:0] rst_o,
  output logic                   gsr_o,
  output logic                   pwroff_o,
  output logic                   ready_o,
  output logic [2:0]             cause_o
);

  localparam int SW = ctr_width(STAGGER);
  localparam int GW = ctr_width(GSRCYCLES);
  localparam int IW = (DOMAINCOUNT > 1) ? $clog2(DOMAINCOUNT) : 1;
  localparam logic [CNTRBITSZ-1:0]   CNTR_FULL = '1;
  localparam logic [DOMAINCOUNT-1:0] ALL_ON    = '1;
  localparam logic [SW-1:0] STAG_LOAD = SW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [GW-1:0] GSR_LOAD  = GW'(GSRCYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DOMAINCOUNT - 1);

  state_t                 state_reg  = HOLD;
  logic [CNTRBITSZ-1:0]   cntr_reg   = '1;
  logic [SW-1:0]          stag_reg   = '0;
  logic [IW-1:0]          idx_reg    = '0;
  logic [GW-1:0]          gcnt_reg   = '0;
  logic [DOMAINCOUNT-1:0] rst_reg    = '1;
  logic                   gsr_reg    = 1'b0;
  logic                   pwroff_reg = 1'b0;
  logic                   ready_reg  = 1'b0;
  logic [2:0]             cause_reg  = CAUSE_POR;

  logic       lock_all;
  logic       evt;
  state_t     evt_state;
  logic [2:0] evt_cause;

  assign lock_all = &locked_i;

  // Event priority for COUNT/RELEASE/RUN: lock loss, power-off, cold, warm, request.
  always_comb begin
    evt       = 1'b1;
    evt_state = COUNT;
    evt_cause = cause_reg;
    if (!lock_all) begin
      evt_state = HOLD;
      evt_cause = CAUSE_LOCKLOSS;
    end else if (swrst_i == SWRST_PWROFF) begin
      evt_state = OFF;
      evt_cause = CAUSE_PWROFF;
    end else if (swrst_i == SWRST_COLD) begin
      evt_state = COLD;
      evt_cause = CAUSE_COLD;
    end else if (swrst_i == SWRST_WARM) begin
      evt_cause = CAUSE_WARM;
    end else if (rqst_i) begin
      evt_cause = CAUSE_RQST;
    end else begin
      evt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= HOLD;
      rst_reg    <= ALL_ON;
      gsr_reg    <= 1'b0;
      pwroff_reg <= 1'b0;
      ready_reg  <= 1'b0;
      cause_reg  <= CAUSE_EXT;
    end else if (state_reg == HOLD) begin
      rst_reg   <= ALL_ON;
      ready_reg <= 1'b0;
      if (swrst_i == SWRST_PWROFF) begin
        state_reg  <= OFF;
        cause_reg  <= CAUSE_PWROFF;
        pwroff_reg <= 1'b1;
      end else if (swrst_i == SWRST_COLD) begin
        state_reg <= COLD;
        cause_reg <= CAUSE_COLD;
        gsr_reg   <= 1'b1;
        gcnt_reg  <= GSR_LOAD;
      end else if (lock_all) begin
        state_reg <= COUNT;
        cntr_reg  <= CNTR_FULL;
      end
    end else if (state_reg == COLD) begin
      if (gcnt_reg == '0) begin
        state_reg <= HOLD;
        gsr_reg   <= 1'b0;
      end else begin
        gcnt_reg <= gcnt_reg - 1'b1;
      end
    end else if (state_reg == OFF) begin
      pwroff_reg <= 1'b1;
    end else if (evt) begin
      state_reg <= evt_state;
      cause_reg <= evt_cause;
      rst_reg   <= ALL_ON;
      ready_reg <= 1'b0;
      cntr_reg  <= CNTR_FULL;
      if (evt_state == OFF) pwroff_reg <= 1'b1;
      if (evt_state == COLD) begin
        gsr_reg  <= 1'b1;
        gcnt_reg <= GSR_LOAD;
      end
    end else if (state_reg == COUNT) begin
      if (cntr_reg != '0) begin
        cntr_reg <= cntr_reg - 1'b1;
      end else if (STAGGER == 0 || DOMAINCOUNT == 1) begin
        rst_reg   <= '0;
        ready_reg <= 1'b1;
        state_reg <= RUN;
      end else begin
        rst_reg[0] <= 1'b0;
        idx_reg    <= IW'(1);
        stag_reg   <= STAG_LOAD;
        state_reg  <= RELEASE;
      end
    end else if (state_reg == RELEASE) begin
      // Domain idx is released once the stagger gap since the previous one has elapsed.
      if (stag_reg != '0) begin
        stag_reg <= stag_reg - 1'b1;
      end else begin
        rst_reg[idx_reg] <= 1'b0;
        stag_reg         <= STAG_LOAD;
        idx_reg          <= idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          ready_reg <= 1'b1;
          state_reg <= RUN;
        end
      end
    end
  end

  assign rst_o    = rst_reg;
  assign gsr_o    = gsr_reg;
  assign pwroff_o = pwroff_reg;
  assign ready_o  = ready_reg;
  assign cause_o  = cause_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with a 4-bit counter, stagger 2 and three domains;
// expected values are hand-derived cycle counts relative to the sampling edge.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] locked_i = 2'b00;
  logic [1:0] swrst_i = 2'b00;
  logic       rqst_i = 1'b0;
  logic [2:0] rst_o;
  logic       gsr_o;
  logic       pwroff_o;
  logic       ready_o;
  logic [2:0] cause_o;

  int total = 0;
  int bad   = 0;

  rst_seq #(
    .DOMAINCOUNT(3),
    .LOCKCOUNT  (2),
    .CNTRBITSZ  (4),
    .STAGGER    (2),
    .GSRCYCLES  (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .locked_i(locked_i),
    .swrst_i (swrst_i),
    .rqst_i  (rqst_i),
    .rst_o   (rst_o),
    .gsr_o   (gsr_o),
    .pwroff_o(pwroff_o),
    .ready_o (ready_o),
    .cause_o (cause_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called in the cycle whose inputs the sequencer samples to start (re)loading;
  // rst_o[0] must drop 'first' edges later, then one domain every 2 edges.
  task automatic release_seq(input string tag, input int first, input logic [2:0] cause);
    tick(first - 1);
    chk({tag, ".pre"}, rst_o, 3'b111);
    tick(1);
    chk({tag, ".d0"}, rst_o, 3'b110);
    chk({tag, ".d0rdy"}, ready_o, 1'b0);
    tick(2);
    chk({tag, ".d1"}, rst_o, 3'b100);
    tick(1);
    chk({tag, ".d1hold"}, rst_o, 3'b100);
    tick(1);
    chk({tag, ".d2"}, rst_o, 3'b000);
    chk({tag, ".rdy"}, ready_o, 1'b1);
    chk({tag, ".cause"}, cause_o, cause);
  endtask

  initial begin
    #1;
    chk("por.rst", rst_o, 3'b111);
    chk("por.gsr", gsr_o, 1'b0);
    chk("por.pwroff", pwroff_o, 1'b0);
    chk("por.ready", ready_o, 1'b0);
    chk("por.cause", cause_o, 3'd0);

    tick(3);
    chk("unlocked.rst", rst_o, 3'b111);

    locked_i = 2'b11;
    release_seq("powerup", 17, 3'd0);

    // Lock loss for one cycle in RUN.
    locked_i = 2'b01;
    tick(1);
    chk("lockloss.rst", rst_o, 3'b111);
    chk("lockloss.cause", cause_o, 3'd2);
    chk("lockloss.ready", ready_o, 1'b0);
    locked_i = 2'b11;
    release_seq("relock", 17, 3'd2);

    // Warm request held for five cycles.
    swrst_i = 2'b10;
    tick(1);
    chk("warm.rst", rst_o, 3'b111);
    chk("warm.cause", cause_o, 3'd4);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("warm.held", rst_o, 3'b111);
    end
    swrst_i = 2'b00;
    release_seq("warm", 16, 3'd4);

    // Request, then external reset in the middle of the release.
    rqst_i = 1'b1;
    tick(1);
    chk("rqst.rst", rst_o, 3'b111);
    chk("rqst.cause", cause_o, 3'd5);
    rqst_i = 1'b0;
    tick(16);
    chk("rqst.d0", rst_o, 3'b110);
    rst_i = 1'b1;
    tick(1);
    chk("ext.rst", rst_o, 3'b111);
    chk("ext.cause", cause_o, 3'd1);
    chk("ext.ready", ready_o, 1'b0);
    rst_i = 1'b0;
    release_seq("ext", 17, 3'd1);

    // Cold reset: gsr_o for exactly four cycles; a power-off request mid-pulse is ignored.
    swrst_i = 2'b11;
    tick(1);
    chk("cold.gsr0", gsr_o, 1'b1);
    chk("cold.rst", rst_o, 3'b111);
    chk("cold.cause", cause_o, 3'd3);
    swrst_i = 2'b01;
    tick(1);
    chk("cold.gsr1", gsr_o, 1'b1);
    swrst_i = 2'b00;
    tick(1);
    chk("cold.gsr2", gsr_o, 1'b1);
    chk("cold.nopwroff", pwroff_o, 1'b0);
    tick(1);
    chk("cold.gsr3", gsr_o, 1'b1);
    tick(1);
    chk("cold.gsrend", gsr_o, 1'b0);
    release_seq("cold", 17, 3'd3);

    // Lock loss wins over a simultaneous cold request.
    locked_i = 2'b01;
    swrst_i  = 2'b11;
    tick(1);
    chk("both.cause", cause_o, 3'd2);
    chk("both.gsr", gsr_o, 1'b0);
    chk("both.rst", rst_o, 3'b111);
    locked_i = 2'b11;
    swrst_i  = 2'b00;
    tick(1);
    chk("both.gsrafter", gsr_o, 1'b0);
    release_seq("both", 16, 3'd2);

    // Power-off is sticky until rst_i.
    swrst_i = 2'b01;
    tick(1);
    chk("off.pwroff", pwroff_o, 1'b1);
    chk("off.rst", rst_o, 3'b111);
    chk("off.cause", cause_o, 3'd6);
    chk("off.ready", ready_o, 1'b0);
    swrst_i = 2'b11;
    tick(5);
    chk("off.cold.gsr", gsr_o, 1'b0);
    chk("off.cold.cause", cause_o, 3'd6);
    swrst_i  = 2'b10;
    locked_i = 2'b00;
    tick(20);
    chk("off.warm.pwroff", pwroff_o, 1'b1);
    chk("off.warm.rst", rst_o, 3'b111);
    swrst_i  = 2'b00;
    locked_i = 2'b11;
    tick(20);
    chk("off.idle.rst", rst_o, 3'b111);
    rst_i = 1'b1;
    tick(1);
    chk("off.ext.pwroff", pwroff_o, 1'b0);
    chk("off.ext.cause", cause_o, 3'd1);
    chk("off.ext.rst", rst_o, 3'b111);
    rst_i = 1'b0;
    release_seq("offexit", 17, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
